// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - shared defaults and types for the voice allocator
package synth_pkg;

    localparam int NUM_KEYS_DFLT   = 13;
    localparam int NUM_VOICES_DFLT = 4;
    localparam int NOTE_W_DFLT     = 4;
    localparam int RANK_W_DFLT     = $clog2(NUM_VOICES_DFLT);

    typedef logic [NOTE_W_DFLT-1:0] note_t;
    typedef logic [RANK_W_DFLT-1:0] rank_t;

    typedef struct packed {
        logic  active;
        note_t note;
    } voice_t;

endpackage

// File: rtl/lru_tracker.sv
// rtl/lru_tracker.sv - recency ranks per voice, 0 = newest, reports the oldest voice
module lru_tracker
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DFLT,
    parameter int RANK_W     = $clog2(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              assign_en,
    input  logic [RANK_W-1:0] assign_voice,
    output logic [RANK_W-1:0] oldest_idx
);

    logic [RANK_W-1:0] rank_q [NUM_VOICES];
    logic [RANK_W-1:0] rank_d [NUM_VOICES];

    // Move the assigned voice to rank 0 and age every voice that was newer than it
    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            rank_d[v] = rank_q[v];
        end
        if (assign_en) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (rank_q[v] < rank_q[assign_voice]) begin
                    rank_d[v] = rank_q[v] + RANK_W'(1);
                end
            end
            rank_d[assign_voice] = '0;
        end
    end

    // The voice holding the highest rank is the steal candidate
    always_comb begin
        oldest_idx = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (rank_q[v] == RANK_W'(NUM_VOICES - 1)) begin
                oldest_idx = RANK_W'(v);
            end
        end
    end

    // Rank registers; reset restores identity order so voice 0 is newest
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (reset) begin
                rank_q[v] <= RANK_W'(v);
            end else begin
                rank_q[v] <= rank_d[v];
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - maps key events onto shared voices, free first then LRU steal
module voice_allocator
    import synth_pkg::*;
#(
    parameter int NUM_KEYS   = NUM_KEYS_DFLT,
    parameter int NUM_VOICES = NUM_VOICES_DFLT,
    parameter int NOTE_W     = NOTE_W_DFLT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_KEYS-1:0]          keys,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_start,
    output logic                         busy
);

    localparam int VIDX_W = $clog2(NUM_VOICES);
    localparam int KIDX_W = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0]   keys_q, keys_d;
    logic [NUM_KEYS-1:0]   pend_on_q, pend_on_d;
    logic [NUM_KEYS-1:0]   pend_off_q, pend_off_d;
    logic [NUM_VOICES-1:0] active_q, active_d;
    logic [NUM_VOICES-1:0] start_q, start_d;
    logic [NOTE_W-1:0]     note_q [NUM_VOICES];
    logic [NOTE_W-1:0]     note_d [NUM_VOICES];

    logic [NUM_KEYS-1:0]   rise, fall, holds;
    logic [NUM_KEYS-1:0]   svc_on_mask, svc_off_mask;
    logic                  off_valid, on_valid, svc_off, svc_on;
    logic [KIDX_W-1:0]     off_key, on_key;
    logic                  free_found;
    logic [VIDX_W-1:0]     free_idx, oldest_idx, target;

    // Key edges and which notes are currently sounding on some voice
    always_comb begin
        keys_d = keys;
        rise   = keys & ~keys_q;
        fall   = ~keys & keys_q;
        holds  = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && note_q[v] == NOTE_W'(k)) begin
                    holds[k] = 1'b1;
                end
            end
        end
    end

    // Pick one event per cycle: lowest pending off first, else lowest pending on
    always_comb begin
        off_valid = |pend_off_q;
        on_valid  = |pend_on_q;
        off_key   = '0;
        on_key    = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pend_off_q[k]) off_key = KIDX_W'(k);
            if (pend_on_q[k])  on_key  = KIDX_W'(k);
        end
        svc_off = off_valid;
        svc_on  = !off_valid && on_valid;
        for (int k = 0; k < NUM_KEYS; k++) begin
            svc_off_mask[k] = svc_off && (off_key == KIDX_W'(k));
            svc_on_mask[k]  = svc_on && (on_key == KIDX_W'(k));
        end
    end

    // Target voice for a key-on: lowest free voice, otherwise the oldest one
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!active_q[v]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(v);
            end
        end
        target = free_found ? free_idx : oldest_idx;
    end

    // Voice register file update for the serviced event
    always_comb begin
        active_d = active_q;
        start_d  = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            note_d[v] = note_q[v];
        end
        if (svc_off) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (active_q[v] && note_q[v] == NOTE_W'(off_key)) begin
                    active_d[v] = 1'b0;
                end
            end
        end
        if (svc_on) begin
            active_d[target] = 1'b1;
            note_d[target]   = NOTE_W'(on_key);
            start_d[target]  = 1'b1;
        end
    end

    // Pending masks; a release of an unserviced press cancels it, keeping the
    // off only when an older instance of that note is still sounding
    always_comb begin
        for (int k = 0; k < NUM_KEYS; k++) begin
            pend_on_d[k]  = (pend_on_q[k] && !svc_on_mask[k] && !fall[k]) || rise[k];
            pend_off_d[k] = (pend_off_q[k] && !svc_off_mask[k]) ||
                            (fall[k] && (!(pend_on_q[k] && !svc_on_mask[k]) || holds[k]));
        end
    end

    lru_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .RANK_W     (VIDX_W)
    ) u_lru (
        .clk          (clk),
        .reset        (reset),
        .assign_en    (svc_on),
        .assign_voice (target),
        .oldest_idx   (oldest_idx)
    );

    // State registers; reset drops all pending events and frees every voice
    always_ff @(posedge clk) begin
        if (reset) begin
            keys_q     <= '0;
            pend_on_q  <= '0;
            pend_off_q <= '0;
            active_q   <= '0;
            start_q    <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
            end
        end else begin
            keys_q     <= keys_d;
            pend_on_q  <= pend_on_d;
            pend_off_q <= pend_off_d;
            active_q   <= active_d;
            start_q    <= start_d;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= note_d[v];
            end
        end
    end

    // Output packing straight from registers
    always_comb begin
        voice_active = active_q;
        voice_start  = start_q;
        busy         = |pend_on_q || |pend_off_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[v*NOTE_W +: NOTE_W] = note_q[v];
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - scoreboard bench with behavioural voice allocation model
module tb_voice_allocator;

    localparam int NK = 13;
    localparam int NV = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NK-1:0] keys = '0;
    logic [NV-1:0] voice_active;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0] voice_start;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    voice_allocator #(
        .NUM_KEYS   (NK),
        .NUM_VOICES (NV),
        .NOTE_W     (NW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .keys         (keys),
        .voice_active (voice_active),
        .voice_note   (voice_note),
        .voice_start  (voice_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NV-1:0]    act;
        logic [NV*NW-1:0] notes;
        logic [NV-1:0]    start;
        logic             busy;
        int               cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // reference model state: sets of pending keys, voice table, recency list (front = newest)
    bit [NK-1:0] m_prev;
    bit [NK-1:0] m_pon;
    bit [NK-1:0] m_poff;
    bit          m_act [NV];
    int          m_note[NV];
    int          m_lru[$];

    task automatic model_step(input bit rst, input bit [NK-1:0] k_in);
        exp_t e;
        bit [NK-1:0] holds;
        int svc_on_k;
        int svc_off_k;
        int tgt;
        e.start = '0;
        if (rst) begin
            m_prev = '0; m_pon = '0; m_poff = '0;
            m_lru.delete();
            for (int v = 0; v < NV; v++) begin
                m_act[v] = 0; m_note[v] = 0; m_lru.push_back(v);
            end
        end else begin
            holds = '0;
            for (int v = 0; v < NV; v++) if (m_act[v]) holds[m_note[v]] = 1'b1;
            svc_on_k = -1; svc_off_k = -1;
            for (int k = NK - 1; k >= 0; k--) if (m_poff[k]) svc_off_k = k;
            if (svc_off_k < 0) for (int k = NK - 1; k >= 0; k--) if (m_pon[k]) svc_on_k = k;
            if (svc_off_k >= 0) begin
                for (int v = 0; v < NV; v++) if (m_act[v] && m_note[v] == svc_off_k) m_act[v] = 0;
            end else if (svc_on_k >= 0) begin
                tgt = -1;
                for (int v = NV - 1; v >= 0; v--) if (!m_act[v]) tgt = v;
                if (tgt < 0) tgt = m_lru[m_lru.size() - 1];
                m_act[tgt] = 1; m_note[tgt] = svc_on_k; e.start[tgt] = 1'b1;
                for (int i = 0; i < m_lru.size(); i++) begin
                    if (m_lru[i] == tgt) begin
                        m_lru.delete(i);
                        break;
                    end
                end
                m_lru.push_front(tgt);
            end
            for (int k = 0; k < NK; k++) begin
                if (k == svc_on_k)  m_pon[k] = 0;
                if (k == svc_off_k) m_poff[k] = 0;
                if (k_in[k] && !m_prev[k]) m_pon[k] = 1;
                if (!k_in[k] && m_prev[k]) begin
                    if (m_pon[k]) begin
                        m_pon[k] = 0;
                        if (holds[k]) m_poff[k] = 1;
                    end else begin
                        m_poff[k] = 1;
                    end
                end
            end
            m_prev = k_in;
        end
        for (int v = 0; v < NV; v++) begin
            e.act[v] = m_act[v];
            e.notes[v*NW +: NW] = NW'(m_note[v]);
        end
        e.busy = (m_pon != 0) || (m_poff != 0);
        e.cyc  = cycle;
        exp_q.push_back(e);
    endtask

    // stimulus side: model the edge and queue the expected outputs
    always @(posedge clk) begin
        cycle++;
        model_step(reset, keys);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want, input int cyc);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // monitor: compare DUT outputs against the oldest expectation, away from the edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("voice_active", 32'(voice_active), 32'(mon_e.act), mon_e.cyc);
            chk("voice_note", 32'(voice_note), 32'(mon_e.notes), mon_e.cyc);
            chk("voice_start", 32'(voice_start), 32'(mon_e.start), mon_e.cyc);
            chk("busy", 32'(busy), 32'(mon_e.busy), mon_e.cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int k);
        keys[k] = 1'b1;
    endtask

    task automatic release_key(input int k);
        keys[k] = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b1; keys = '0;
        tick(3);
        reset = 1'b0;
        tick(5);

        // single note on and off
        press(4); tick(4);
        release_key(4); tick(4);

        // three simultaneous presses
        press(0); press(7); press(12); tick(6);
        keys = '0; tick(6);

        // fill all voices then steal
        press(1); tick(3); press(2); tick(3); press(3); tick(3); press(4); tick(3);
        press(9); tick(4);
        release_key(1); tick(3);
        release_key(2); tick(3);
        keys = '0; tick(10);

        // release and press in the same cycle with all voices busy
        press(0); press(5); press(8); press(10); tick(8);
        release_key(5); press(6); tick(6);
        keys = '0; tick(10);

        // press then release before the press is serviced
        press(2); press(3); tick(1);
        release_key(3); tick(6);
        keys = '0; tick(6);
        press(3); tick(1);
        release_key(3); tick(6);

        // reset in the middle of a burst, keys still held afterwards
        press(0); press(1); press(2); tick(2);
        reset = 1'b1; tick(1);
        reset = 1'b0; tick(8);
        keys = '0; tick(8);

        // randomized key activity with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, NK - 1)] ^= 1'b1;
            reset = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        reset = 1'b0;
        keys = '0;
        tick(20);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0 queued expectations", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
